p4r2_tx: RTL and testbench
==========================

Name: p4r2_tx

Overview:
Clocked transmitter that sources a 4-phase dual-rail (return-to-zero) channel from a synchronous valid/ready word interface. It is the producing end for the dual-rail gate library (p4r2_* cells, cmuller-based logic). It encodes each accepted binary word into a dual-rail codeword, waits for the receiver's acknowledge, then drives the spacer and waits for acknowledge release before taking the next word.

Parameters:
WIDTH, 8, number of data bits; the channel has 2*WIDTH rails.
SYNC_STAGES, 2, flop stages synchronising the asynchronous ack input (minimum 2).

Ports:
clk  input  1  single clock; all state is in this domain.
rstn  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  binary word to send.
valid_in  input  1  data_in is valid.
ready_out  output  1  transmitter can accept a word this cycle.
y  output  2*WIDTH  dual-rail channel; bit i uses y[2i] = false rail (d.f) and y[2i+1] = true rail (d.t).
ack  input  1  receiver acknowledge, asynchronous to clk, 4-phase.
busy  output  1  handshake in progress (state != IDLE).
proto_err  output  1  sticky: ack seen high while IDLE.

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE, y=all 0 (spacer), busy=0, proto_err=0, synchroniser flops=0. This takes effect immediately, including mid-handshake. The receiver sees the spacer, and the next transfer starts clean after reset release.
- ack passes through SYNC_STAGES flops to produce ack_s. Only ack_s is used internally.
- FSM states:
  - IDLE: y=spacer. ready_out = (ack_s==0). If valid_in & ready_out, register data_in and go to DATA.
  - DATA: y = codeword. For each bit i: y[2i+1]=d[i], y[2i]=~d[i]. Stay until ack_s==1, then go to RTZ.
  - RTZ: y=spacer. Stay until ack_s==0, then go to IDLE.
- y is driven directly from flops, never through combinational logic, so the channel has no glitches.
- Rail monotonicity: rails only rise on entering DATA and only fall on entering RTZ. Exactly one rail per bit is high in DATA.
- Latency: the codeword appears on y on the clock edge that accepts the word (registered). One full transfer takes at least 1 + 2*SYNC_STAGES + 2 cycles plus receiver delay, which is 7 cycles with zero receiver delay at default settings.
- ready_out is 0 in DATA and RTZ. data_in and valid_in are ignored outside IDLE. No word is lost: the producer holds valid_in until it sees ready_out.
- ack_s==1 while in IDLE (stale or early ack):
  - ready_out=0, so nothing is sent.
  - proto_err sets and stays set until reset.
  - The FSM stays in IDLE until ack_s falls, then resumes normally.
- ack falling while in DATA (glitch or early release): ignored; the FSM keeps waiting for ack_s==1.
- ack rising while in RTZ: ignored; the FSM keeps waiting for ack_s==0.
- valid_in asserted in the same cycle that RTZ exits to IDLE: not accepted. Acceptance requires state==IDLE at the sampling edge, so at least one spacer cycle separates codewords in IDLE.
- WIDTH=1 is legal. The module holds no storage beyond the WIDTH-bit data register, the FSM, the synchroniser and proto_err.

Decomposition:
- Shared package p4r2_pkg holds:
  - rail index constants RAIL_F=0 and RAIL_T=1, and the spacer value 2'b00;
  - the FSM state enum (IDLE, DATA, RTZ);
  - function p4r2_encode(bin word) returning the 2*WIDTH codeword.
- Sub-module p4r2_sync: a SYNC_STAGES-deep flop synchroniser with asynchronous active-low reset to 0. It is reused later by the matching receiver.

Test Plan:
- Reset then idle, with ack=0 and valid_in=0 -> y=16'h0000, ready_out=1, busy=0, proto_err=0.
- Send data_in=8'hA5 with a receiver model that acks 3 cycles after a complete codeword:
  - y = 16'b1001_1001_0110_0110 (bit7..0 pairs {T,F}).
  - ack up -> y=0 within 2 sync + 1 cycles.
  - ack down -> ready_out=1 again.
  - Decoded word = 8'hA5.
- Back-to-back words 8'h00, 8'hFF, 8'h3C with valid_in held high:
  - each word appears exactly once, in order;
  - a spacer always separates codewords;
  - no rail falls in DATA and no rail rises in RTZ (checker on all 16 rails).
- ack held high before the first word -> ready_out=0, proto_err=1, y stays 0. After ack drops, 8'h81 is sent correctly and proto_err stays 1.
- Assert rstn low while in DATA holding 8'h5A -> y=0 in the same cycle (asynchronously), busy=0. After release, 8'h12 is sent cleanly.
- 1-cycle ack pulse shorter than one clock period during DATA (may or may not sync) -> FSM either stays in DATA or completes the handshake. Never a duplicate codeword, never a rail violation. Random ack delay of 0-20 cycles over 1000 words -> zero mismatches.

Source files
------------

// File: rtl/p4r2_pkg.sv
// Shared definitions for the p4r2 dual-rail channel: rail indices, spacer,
// handshake FSM states and the binary-to-dual-rail encoder.
package p4r2_pkg;

   localparam int         RAIL_F     = 0;
   localparam int         RAIL_T     = 1;
   localparam logic [1:0] SPACER     = 2'b00;
   localparam int         P4R2_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RTZ  = 2'd2
   } p4r2_state_e;

   // Encodes up to P4R2_MAX_W bits; callers zero-extend and truncate to their width.
   function automatic logic [2*P4R2_MAX_W-1:0] p4r2_encode(input logic [P4R2_MAX_W-1:0] bin);
      logic [2*P4R2_MAX_W-1:0] code;
      code = '0;
      for (int i = 0; i < P4R2_MAX_W; i++) begin
         code[2*i+RAIL_T] = bin[i];
         code[2*i+RAIL_F] = ~bin[i];
      end
      return code;
   endfunction

endpackage

// File: rtl/p4r2_sync.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module p4r2_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_sync <= '0;
      else         r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/p4r2_tx.sv
// 4-phase dual-rail (return-to-zero) transmitter fed by a valid/ready word port.
// The channel rails come straight from flops so the receiver never sees glitches.
module p4r2_tx
   import p4r2_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               valid_in,
   output logic               ready_out,
   output logic [2*WIDTH-1:0] y,
   input  logic               ack,
   output logic               busy,
   output logic               proto_err,
   output p4r2_state_e        dbg_state
);

   // Word side: a word moves when valid_in & ready_out are both high at a rising
   // clk edge; the producer holds valid_in and data_in until then.
   logic               w_ack_s;
   logic               w_accept;
   logic               w_release;
   p4r2_state_e        r_state;
   p4r2_state_e        w_next;
   logic [2*WIDTH-1:0] r_y;
   logic               r_proto_err;

   p4r2_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_d    (ack),
      .o_q    (w_ack_s)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (valid_in && !w_ack_s) w_next = DATA;
         DATA:    if (w_ack_s)              w_next = RTZ;
         RTZ:     if (!w_ack_s)             w_next = IDLE;
         default:                           w_next = IDLE;
      endcase
   end

   always_comb begin
      ready_out = (r_state == IDLE) && !w_ack_s;
      busy      = (r_state != IDLE);
      w_accept  = ready_out && valid_in;
      w_release = (r_state == DATA) && w_ack_s;
   end

   // The rail register doubles as the word store: rails rise only on accept
   // and all fall together when the receiver acknowledges.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_y         <= {WIDTH{SPACER}};
         r_proto_err <= 1'b0;
      end else begin
         if (w_accept)
            r_y <= (2*WIDTH)'(p4r2_encode(P4R2_MAX_W'(data_in)));
         else if (w_release)
            r_y <= {WIDTH{SPACER}};
         if ((r_state == IDLE) && w_ack_s)
            r_proto_err <= 1'b1;
      end
   end

   assign y         = r_y;
   assign proto_err = r_proto_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_p4r2_tx.sv
// Bench for p4r2_tx: randomised producer and receiver, queue-based scoreboard
// that decodes every codeword, plus a rail-monotonicity watcher.
`timescale 1ns/1ps
module tb_p4r2_tx;

   localparam int W = 8;

   logic           clk      = 1'b0;
   logic           rstn     = 1'b1;
   logic [W-1:0]   data_in  = '0;
   logic           valid_in = 1'b0;
   logic           ready_out;
   logic [2*W-1:0] y;
   logic           ack      = 1'b0;
   logic           busy;
   logic           proto_err;
   logic [1:0]     dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [W-1:0] exp_q[$];

   bit rx_en      = 1'b0;
   bit rand_delay = 1'b0;
   int rx_delay   = 3;
   int rx_d;
   logic [2*W-1:0] prev_y = '0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   p4r2_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .y         (y),
      .ack       (ack),
      .busy      (busy),
      .proto_err (proto_err),
      .dbg_state (dbg_state)
   );

   // ---------------- reference helpers ----------------
   function automatic bit is_code(input logic [2*W-1:0] c);
      for (int i = 0; i < W; i++)
         if (c[2*i] == c[2*i+1]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W-1:0] decode(input logic [2*W-1:0] c);
      logic [W-1:0] d;
      for (int i = 0; i < W; i++) d[i] = c[2*i+1];
      return d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired, state=%0d y=0x%0h (t=%0t)", name, dbg_state, y, $time);
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [W-1:0] w);
      int t;
      t = 0;
      data_in  = w;
      valid_in = 1'b1;
      while (!ready_out && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!ready_out) begin
         fail_now("send_timeout");
      end else begin
         exp_q.push_back(w);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(busy == 1'b0 && ack == 1'b0 && y == '0 && ready_out == 1'b1) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) fail_now("idle_timeout");
   endtask

   // ---------------- receiver model ----------------
   always begin
      @(negedge clk);
      if (rx_en && rstn) begin
         if (!ack && is_code(y)) begin
            rx_d = rand_delay ? int'($urandom_range(0, 20)) : rx_delay;
            repeat (rx_d) @(negedge clk);
            #2 ack = 1'b1;
         end else if (ack && y == '0) begin
            rx_d = rand_delay ? int'($urandom_range(0, 20)) : rx_delay;
            repeat (rx_d) @(negedge clk);
            #2 ack = 1'b0;
         end
      end
   end

   // ---------------- scoreboard monitor + rail checker ----------------
   always @(negedge clk) begin
      if (y !== prev_y) begin
         if (prev_y == '0) begin
            check("codeword_one_rail_per_bit", 32'(is_code(y)), 32'd1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h, required no word (t=%0t)", decode(y), $time);
            end else begin
               check("word_order", 32'(decode(y)), 32'(exp_q.pop_front()));
            end
         end else begin
            check("rails_fall_to_spacer", 32'(y), 32'd0);
         end
         prev_y = y;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      fail_now("global_watchdog");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic [W-1:0] w;
      #1 rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);

      // reset / idle state
      check("reset_y", 32'(y), 32'd0);
      check("reset_ready", 32'(ready_out), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_proto_err", 32'(proto_err), 32'd0);

      // single word A5 with a hand-driven acknowledge
      send_word(8'hA5);
      valid_in = 1'b0;
      check("a5_codeword", 32'(y), 32'h9966);
      check("a5_busy", 32'(busy), 32'd1);
      check("a5_ready_low", 32'(ready_out), 32'd0);
      repeat (3) @(negedge clk);
      check("a5_held", 32'(y), 32'h9966);
      #2 ack = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (y != '0 && n < 10);
      check("ack_to_spacer_within_3", 32'(n <= 3), 32'd1);
      check("rtz_ready_low", 32'(ready_out), 32'd0);
      repeat (2) @(negedge clk);
      #2 ack = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!ready_out && n < 10);
      check("release_to_ready_within_3", 32'(n <= 3), 32'd1);
      check("a5_no_proto_err", 32'(proto_err), 32'd0);

      // back-to-back words with valid held high
      rx_en = 1'b1;
      rx_delay = 3;
      send_word(8'h00);
      send_word(8'hFF);
      send_word(8'h3C);
      valid_in = 1'b0;
      wait_idle();
      check("b2b_all_delivered", 32'(exp_q.size()), 32'd0);
      rx_en = 1'b0;

      // stale ack before the first word
      do_reset();
      #2 ack = 1'b1;
      repeat (3) @(negedge clk);
      data_in  = 8'h81;
      valid_in = 1'b1;
      repeat (4) @(negedge clk);
      check("stale_ack_ready", 32'(ready_out), 32'd0);
      check("stale_ack_proto_err", 32'(proto_err), 32'd1);
      check("stale_ack_y", 32'(y), 32'd0);
      check("stale_ack_busy", 32'(busy), 32'd0);
      #2 ack = 1'b0;
      @(negedge clk);
      rx_en = 1'b1;
      send_word(8'h81);
      valid_in = 1'b0;
      wait_idle();
      check("proto_err_sticky", 32'(proto_err), 32'd1);
      check("w81_delivered", 32'(exp_q.size()), 32'd0);
      rx_en = 1'b0;

      // asynchronous reset mid-DATA
      send_word(8'h5A);
      valid_in = 1'b0;
      check("5a_in_data", 32'(busy), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("async_rst_y", 32'(y), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_proto_err", 32'(proto_err), 32'd0);
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      rx_en = 1'b1;
      send_word(8'h12);
      valid_in = 1'b0;
      wait_idle();
      check("post_reset_delivered", 32'(exp_q.size()), 32'd0);
      rx_en = 1'b0;

      // sub-period ack pulses during DATA
      for (int k = 0; k < 20; k++) begin
         w = W'($urandom);
         send_word(w);
         valid_in = 1'b0;
         #($urandom_range(0, 9)) ack = 1'b1;
         #3 ack = 1'b0;
         repeat (5) @(negedge clk);
         rx_en = 1'b1;
         wait_idle();
         rx_en = 1'b0;
         @(negedge clk);
      end
      check("pulse_words_delivered", 32'(exp_q.size()), 32'd0);

      // random words, random receiver delay
      rx_en = 1'b1;
      rand_delay = 1'b1;
      for (int k = 0; k < 1000 && n_fail <= 20; k++) begin
         send_word(W'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      valid_in = 1'b0;
      wait_idle();
      check("random_all_delivered", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
